// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and DataMemory-side signals of the data memory arbiter.
//   Requester side: req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (to arbiter);
//                   ack0/ack1, rdata, busy (from arbiter).
//   Memory side:    mem_rd, mem_wr, mem_addr, mem_wdata (from arbiter); mem_rdata (to arbiter).
//   slave modport is the arbiter's view; master modport is the environment's view.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned MEM_ADDR_W = 32;

   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_W-1:0]     addr0;
   logic [ADDR_W-1:0]     addr1;
   logic [DATA_W-1:0]     wdata0;
   logic [DATA_W-1:0]     wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [DATA_W-1:0]     rdata;
   logic                  busy;
   logic                  mem_rd;
   logic                  mem_wr;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata, busy, mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata, busy, mem_rd, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer sharing the single DataMemory port between
// the CPU load/store path (port 0) and the program/debug loader (port 1).
// Each grant runs IDLE -> ACCESS (one memory strobe cycle) -> RESP (one ack cycle).
// Ports:
//   clk  - single clock, all state changes on posedge
//   rst  - synchronous active-high reset
//   bus  - dmem_arbiter_if.slave: requester handshakes plus DataMemory strobes/data
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
) (
   input logic          clk,
   input logic          rst,
   dmem_arbiter_if.slave bus
);
   localparam int unsigned MEM_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state;
   logic                last;
   logic                id_l;
   logic                we_l;
   logic [ADDR_W-1:0]   addr_l;
   logic [DATA_W-1:0]   wdata_l;
   logic                ack0_r;
   logic                ack1_r;
   logic                busy_r;
   logic                mem_rd_r;
   logic                mem_wr_r;

   logic                cand0_c;
   logic                cand1_c;
   logic                grant_c;
   logic                win_c;

   // Arbitration: the port being acked in RESP still holds req, so it is excluded.
   always_comb begin
      cand0_c = bus.req0 && !((state == RESP) && (id_l == 1'b0));
      cand1_c = bus.req1 && !((state == RESP) && (id_l == 1'b1));
      grant_c = (state != ACCESS) && (cand0_c || cand1_c);
      if (cand0_c && cand1_c) begin
         win_c = ~last;
      end else begin
         win_c = cand1_c;
      end
   end

   // Sequencer: grant/latch, one-cycle memory strobe, one-cycle ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         id_l     <= 1'b0;
         we_l     <= 1'b0;
         addr_l   <= '0;
         wdata_l  <= '0;
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         busy_r   <= 1'b0;
         mem_rd_r <= 1'b0;
         mem_wr_r <= 1'b0;
      end else begin
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         mem_rd_r <= 1'b0;
         mem_wr_r <= 1'b0;
         case (state)
            ACCESS: begin
               state  <= RESP;
               busy_r <= 1'b1;
               ack0_r <= ~id_l;
               ack1_r <= id_l;
            end
            default: begin
               if (grant_c) begin
                  state    <= ACCESS;
                  busy_r   <= 1'b1;
                  id_l     <= win_c;
                  last     <= win_c;
                  we_l     <= win_c ? bus.we1 : bus.we0;
                  addr_l   <= win_c ? bus.addr1 : bus.addr0;
                  wdata_l  <= win_c ? bus.wdata1 : bus.wdata0;
                  mem_rd_r <= win_c ? ~bus.we1 : ~bus.we0;
                  mem_wr_r <= win_c ? bus.we1 : bus.we0;
               end else begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.ack0      = ack0_r;
   assign bus.ack1      = ack1_r;
   assign bus.busy      = busy_r;
   assign bus.mem_rd    = mem_rd_r;
   assign bus.mem_wr    = mem_wr_r;
   assign bus.mem_addr  = MEM_ADDR_W'(addr_l);
   assign bus.mem_wdata = wdata_l;
   // MemOut is already registered by the memory, so read data is forwarded in RESP.
   assign bus.rdata     = ((state == RESP) && !we_l) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized two-port traffic checked against a
// transaction-level round-robin model and a reference memory.
module tb_dmem_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   dmem_arbiter_if bus ();

   dmem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // DataMemory behaviour: write on negedge, registered read on posedge, plus a preload port.
   logic [31:0] mem [0:65535];
   logic [31:0] mem_q;
   logic        pl_en;
   logic [15:0] pl_addr;
   logic [31:0] pl_data;

   always @(negedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (bus.mem_wr) mem[bus.mem_addr[15:0]] <= bus.mem_wdata;
   end
   always @(posedge clk) begin
      if (bus.mem_rd) mem_q <= mem[bus.mem_addr[15:0]];
   end
   assign bus.mem_rdata = mem_q;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(negedge clk);
      #1;
      pl_en   = 1'b0;
   endtask

   task automatic drop_all();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.we0  = 1'b0; bus.we1  = 1'b0;
      bus.addr0 = '0;  bus.addr1 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0;
   endtask

   task automatic do_reset();
      drop_all();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drop_all();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (bus.ack0 !== 1'b0) begin n_err++; $display("FAIL reset_ack0: got %b want 0", bus.ack0); end
      n_cmp++; if (bus.ack1 !== 1'b0) begin n_err++; $display("FAIL reset_ack1: got %b want 0", bus.ack1); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", bus.mem_rd, bus.mem_wr); end
      n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", bus.mem_addr, bus.mem_wdata); end
      n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
      rst = 1'b0;
      tick();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_port0_read();
      do_reset();
      preload(16'd5, 32'hDEADBEEF);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd5; bus.wdata0 = $urandom;
      tick();
      n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL p0rd_strobe: got rd=%b wr=%b want 1/0", bus.mem_rd, bus.mem_wr); end
      n_cmp++; if (bus.mem_addr !== 32'd5) begin n_err++; $display("FAIL p0rd_addr: got %h want 5", bus.mem_addr); end
      n_cmp++; if (bus.ack0 !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL p0rd_access: got ack0=%b busy=%b want 0/1", bus.ack0, bus.busy); end
      tick();
      n_cmp++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL p0rd_strobe_len: got %b want 0", bus.mem_rd); end
      n_cmp++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin n_err++; $display("FAIL p0rd_ack: got ack0=%b ack1=%b want 1/0", bus.ack0, bus.ack1); end
      n_cmp++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL p0rd_rdata: got %h want deadbeef", bus.rdata); end
      tick();
      bus.req0 = 1'b0;
      n_cmp++; if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL p0rd_done: got ack0=%b busy=%b rd=%b want 0/0/0", bus.ack0, bus.busy, bus.mem_rd); end
      tick();
   endtask

   task automatic test_port1_write_read();
      do_reset();
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'hFFFF; bus.wdata1 = 32'h12345678;
      tick();
      n_cmp++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL p1wr_strobe: got wr=%b rd=%b want 1/0", bus.mem_wr, bus.mem_rd); end
      n_cmp++; if (bus.mem_addr !== 32'h0000FFFF) begin n_err++; $display("FAIL p1wr_addr: got %h want 0000ffff", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL p1wr_wdata: got %h want 12345678", bus.mem_wdata); end
      tick();
      n_cmp++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL p1wr_strobe_len: got %b want 0", bus.mem_wr); end
      n_cmp++; if (bus.ack1 !== 1'b1 || bus.rdata !== 32'h0) begin n_err++; $display("FAIL p1wr_ack: got ack1=%b rdata=%h want 1/0", bus.ack1, bus.rdata); end
      tick();
      bus.we1 = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin n_err++; $display("FAIL p1_idle_between: got busy=%b ack1=%b want 0/0", bus.busy, bus.ack1); end
      tick();
      n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h0000FFFF) begin n_err++; $display("FAIL p1rd_access: got rd=%b addr=%h want 1/0000ffff", bus.mem_rd, bus.mem_addr); end
      tick();
      n_cmp++; if (bus.ack1 !== 1'b1 || bus.rdata !== 32'h12345678) begin n_err++; $display("FAIL p1rd_data: got ack1=%b rdata=%h want 1/12345678", bus.ack1, bus.rdata); end
      tick();
      bus.req1 = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      logic [31:0] v1, v2;
      v1 = $urandom; v2 = $urandom;
      do_reset();
      preload(16'd1, v1);
      preload(16'd2, v2);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd1;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd2;
      tick();
      n_cmp++; if (bus.mem_addr !== 32'd1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL sim_first_grant: got addr=%h busy=%b want 1/1", bus.mem_addr, bus.busy); end
      tick();
      n_cmp++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.rdata !== v1) begin n_err++; $display("FAIL sim_ack0: got ack0=%b ack1=%b rdata=%h want 1/0/%h", bus.ack0, bus.ack1, bus.rdata, v1); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sim_busy_resp0: got %b want 1", bus.busy); end
      tick();
      bus.req0 = 1'b0;
      n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd2 || bus.busy !== 1'b1) begin n_err++; $display("FAIL sim_second_grant: got rd=%b addr=%h busy=%b want 1/2/1", bus.mem_rd, bus.mem_addr, bus.busy); end
      tick();
      n_cmp++; if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.rdata !== v2) begin n_err++; $display("FAIL sim_ack1: got ack1=%b ack0=%b rdata=%h want 1/0/%h", bus.ack1, bus.ack0, bus.rdata, v2); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sim_busy_resp1: got %b want 1", bus.busy); end
      tick();
      bus.req1 = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sim_end_busy: got %b want 0", bus.busy); end
      tick();
   endtask

   task automatic test_fairness();
      int order[$];
      int c0, c1;
      do_reset();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd1;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd2;
      for (int i = 0; i < 30 && order.size() < 8; i++) begin
         tick();
         n_cmp++; if (bus.ack0 && bus.ack1) begin n_err++; $display("FAIL fair_both_ack: got 1/1 want at most one"); end
         if (bus.ack0) order.push_back(0);
         if (bus.ack1) order.push_back(1);
      end
      drop_all();
      n_cmp++; if (order.size() != 8) begin n_err++; $display("FAIL fair_count: got %0d acks want 8", order.size()); end
      c0 = 0; c1 = 0;
      foreach (order[i]) begin
         if (order[i] == 0) c0++; else c1++;
         n_cmp++; if (order[i] != (i % 2)) begin n_err++; $display("FAIL fair_order[%0d]: got port %0d want port %0d", i, order[i], i % 2); end
      end
      n_cmp++; if (c0 != 4 || c1 != 4) begin n_err++; $display("FAIL fair_split: got %0d/%0d want 4/4", c0, c1); end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] v3, v4;
      v3 = $urandom; v4 = $urandom;
      do_reset();
      preload(16'd3, v3);
      preload(16'd4, v4);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd3;
      tick();
      n_cmp++; if (bus.mem_rd !== 1'b1) begin n_err++; $display("FAIL rstmid_access: got rd=%b want 1", bus.mem_rd); end
      rst = 1'b1;
      tick();
      n_cmp++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl: got ack0=%b ack1=%b busy=%b want 0/0/0", bus.ack0, bus.ack1, bus.busy); end
      n_cmp++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_bus: got rd=%b wr=%b addr=%h wdata=%h rdata=%h want all 0", bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.rdata); end
      rst = 1'b0;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd4;
      tick();
      n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd3) begin n_err++; $display("FAIL rstmid_tie: got rd=%b addr=%h want 1/3", bus.mem_rd, bus.mem_addr); end
      tick();
      n_cmp++; if (bus.ack0 !== 1'b1 || bus.rdata !== v3) begin n_err++; $display("FAIL rstmid_ack0: got ack0=%b rdata=%h want 1/%h", bus.ack0, bus.rdata, v3); end
      tick();
      bus.req0 = 1'b0;
      tick();
      n_cmp++; if (bus.ack1 !== 1'b1 || bus.rdata !== v4) begin n_err++; $display("FAIL rstmid_ack1: got ack1=%b rdata=%h want 1/%h", bus.ack1, bus.rdata, v4); end
      tick();
      bus.req1 = 1'b0;
      tick();
   endtask

   // Random traffic against a transaction-level model: which port is in its access cycle,
   // which is in its ack cycle, round-robin choice, and a reference memory.
   task automatic test_random();
      logic [31:0] ref_mem [16];
      logic [31:0] exp_rd [2];
      logic        rel [2];
      logic        c0, c1, g_we;
      logic [15:0] g_addr;
      logic [31:0] g_wd;
      int          m_acc, m_resp, m_last, n_acc, win;
      do_reset();
      for (int a = 0; a < 16; a++) begin
         ref_mem[a] = $urandom;
         preload(16'(a), ref_mem[a]);
      end
      exp_rd[0] = '0; exp_rd[1] = '0; rel[0] = 1'b0; rel[1] = 1'b0;
      g_we = 1'b0; g_addr = '0; g_wd = '0;
      m_acc = -1; m_resp = -1; m_last = 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         n_acc = -1;
         if (m_acc < 0) begin
            c0 = bus.req0 && (m_resp != 0);
            c1 = bus.req1 && (m_resp != 1);
            if (c0 || c1) begin
               win = (c0 && c1) ? (1 - m_last) : (c0 ? 0 : 1);
               m_last = win;
               n_acc  = win;
               g_we   = (win == 1) ? bus.we1 : bus.we0;
               g_addr = (win == 1) ? bus.addr1 : bus.addr0;
               g_wd   = (win == 1) ? bus.wdata1 : bus.wdata0;
               if (g_we) begin
                  ref_mem[g_addr[3:0]] = g_wd;
                  exp_rd[win] = '0;
               end else begin
                  exp_rd[win] = ref_mem[g_addr[3:0]];
               end
            end
         end
         m_resp = m_acc;
         m_acc  = n_acc;
         tick();
         n_cmp++; if (bus.ack0 !== (m_resp == 0) || bus.ack1 !== (m_resp == 1)) begin n_err++; $display("FAIL rnd_ack c%0d: got %b%b want %b%b", cyc, bus.ack0, bus.ack1, m_resp == 0, m_resp == 1); end
         n_cmp++; if (bus.rdata !== ((m_resp >= 0) ? exp_rd[m_resp] : 32'h0)) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, bus.rdata, (m_resp >= 0) ? exp_rd[m_resp] : 32'h0); end
         n_cmp++; if (bus.mem_rd !== (m_acc >= 0 && !g_we) || bus.mem_wr !== (m_acc >= 0 && g_we)) begin n_err++; $display("FAIL rnd_strobe c%0d: got rd=%b wr=%b want rd=%b wr=%b", cyc, bus.mem_rd, bus.mem_wr, m_acc >= 0 && !g_we, m_acc >= 0 && g_we); end
         n_cmp++; if (bus.busy !== (m_acc >= 0 || m_resp >= 0)) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, bus.busy, m_acc >= 0 || m_resp >= 0); end
         if (m_acc >= 0) begin
            n_cmp++; if (bus.mem_addr !== 32'(g_addr) || (g_we && bus.mem_wdata !== g_wd)) begin n_err++; $display("FAIL rnd_membus c%0d: got addr=%h wdata=%h want addr=%h wdata=%h", cyc, bus.mem_addr, bus.mem_wdata, 32'(g_addr), g_wd); end
         end
         // Requesters: hold until ack, release in the cycle after ack, then maybe re-request.
         if (rel[0]) begin bus.req0 = 1'b0; rel[0] = 1'b0; end
         if (bus.ack0) rel[0] = 1'b1;
         else if (!bus.req0 && $urandom_range(2) != 0) begin
            bus.req0 = 1'b1; bus.we0 = 1'($urandom_range(1));
            bus.addr0 = 16'($urandom_range(15)); bus.wdata0 = $urandom;
         end
         if (rel[1]) begin bus.req1 = 1'b0; rel[1] = 1'b0; end
         if (bus.ack1) rel[1] = 1'b1;
         else if (!bus.req1 && $urandom_range(2) != 0) begin
            bus.req1 = 1'b1; bus.we1 = 1'($urandom_range(1));
            bus.addr1 = 16'($urandom_range(15)); bus.wdata1 = $urandom;
         end
      end
      drop_all();
      tick(); tick(); tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      pl_en = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      rst = 1'b1;
      drop_all();
      test_reset();
      test_port0_read();
      test_port1_write_read();
      test_simultaneous();
      test_fairness();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
